// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - E-stage multiply/divide sequencer owning HI/LO
module muldiv_ctrl #(
  parameter bit          BYPASS    = 1'b1,
  parameter logic [31:0] HILO_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic        e_kill,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  output logic [31:0] md_rdata,
  output logic        md_stall,
  output logic        md_busy,
  output logic [31:0] mdu_src0,
  output logic [31:0] mdu_src1,
  output logic [1:0]  mdu_op,
  output logic        mdu_sign,
  output logic        mdu_in_valid,
  input  logic        mdu_in_ready,
  output logic        mdu_out_ready,
  input  logic        mdu_out_valid,
  input  logic [31:0] mdu_res0,
  input  logic [31:0] mdu_res1
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state;
  logic [31:0] hi, lo;

  logic is_arith, is_mul, is_mf, is_mt, is_real;
  logic issue, bypass_hit, mt_write;

  assign is_arith = (e_md_op >= OP_MULT) && (e_md_op <= OP_DIVU);
  assign is_mul   = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
  assign is_mf    = (e_md_op == OP_MFHI) || (e_md_op == OP_MFLO);
  assign is_mt    = (e_md_op == OP_MTHI) || (e_md_op == OP_MTLO);
  assign is_real  = (e_md_op != 4'd0) && (e_md_op <= OP_MTLO);

  assign issue      = (state == ST_IDLE) && e_valid && !e_kill && is_arith && mdu_in_ready;
  assign bypass_hit = BYPASS && (state == ST_WAIT) && mdu_out_valid;

  assign mdu_in_valid  = issue;
  assign mdu_op        = issue ? (is_mul ? 2'b01 : 2'b10) : 2'b00;
  assign mdu_sign      = issue && ((e_md_op == OP_MULT) || (e_md_op == OP_DIV));
  assign mdu_src0      = e_rs;
  assign mdu_src1      = e_rt;
  assign mdu_out_ready = (state == ST_WAIT);
  assign md_busy       = (state == ST_WAIT);

  // Only an MF can slip past WAIT, and only when it can take the result off the unit's bus.
  assign md_stall = e_valid && is_real &&
                    (((state == ST_WAIT) && !(is_mf && bypass_hit)) ||
                     ((state == ST_IDLE) && is_arith && !mdu_in_ready));

  assign mt_write = e_valid && !e_kill && is_mt && !md_stall;

  always_comb begin
    md_rdata = 32'h0;
    if (is_mf) begin
      if (bypass_hit) md_rdata = (e_md_op == OP_MFHI) ? mdu_res1 : mdu_res0;
      else            md_rdata = (e_md_op == OP_MFHI) ? hi : lo;
    end
  end

  // MT always stalls in WAIT, so it can never collide with the completion write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      hi    <= HILO_INIT;
      lo    <= HILO_INIT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) state <= ST_WAIT;
          if (mt_write) begin
            if (e_md_op == OP_MTHI) hi <= e_rs;
            else                    lo <= e_rs;
          end
        end
        ST_WAIT: begin
          if (mdu_out_valid) begin
            hi    <= mdu_res1;
            lo    <= mdu_res0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - randomized and directed bench for muldiv_ctrl (BYPASS=1 and BYPASS=0)
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset, e_valid, e_kill, mdu_in_ready;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs, e_rt;

  // behavioural multiply/divide unit
  logic        u_busy = 1'b0;
  int          u_cnt = 0;
  int          force_lat = -1;
  logic [31:0] u_res0 = 32'h0, u_res1 = 32'h0;
  logic        mdu_out_valid;
  assign mdu_out_valid = u_busy && (u_cnt == 0);

  logic [31:0] md_rdata_1, md_rdata_0, mdu_src0_1, mdu_src0_0, mdu_src1_1, mdu_src1_0;
  logic        md_stall_1, md_stall_0, md_busy_1, md_busy_0;
  logic [1:0]  mdu_op_1, mdu_op_0;
  logic        mdu_sign_1, mdu_sign_0, mdu_in_valid_1, mdu_in_valid_0;
  logic        mdu_out_ready_1, mdu_out_ready_0;

  muldiv_ctrl #(.BYPASS(1'b1), .HILO_INIT(32'h0)) dut1 (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_kill(e_kill), .e_md_op(e_md_op),
    .e_rs(e_rs), .e_rt(e_rt), .md_rdata(md_rdata_1), .md_stall(md_stall_1), .md_busy(md_busy_1),
    .mdu_src0(mdu_src0_1), .mdu_src1(mdu_src1_1), .mdu_op(mdu_op_1), .mdu_sign(mdu_sign_1),
    .mdu_in_valid(mdu_in_valid_1), .mdu_in_ready(mdu_in_ready), .mdu_out_ready(mdu_out_ready_1),
    .mdu_out_valid(mdu_out_valid), .mdu_res0(u_res0), .mdu_res1(u_res1));

  muldiv_ctrl #(.BYPASS(1'b0), .HILO_INIT(32'h0)) dut0 (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_kill(e_kill), .e_md_op(e_md_op),
    .e_rs(e_rs), .e_rt(e_rt), .md_rdata(md_rdata_0), .md_stall(md_stall_0), .md_busy(md_busy_0),
    .mdu_src0(mdu_src0_0), .mdu_src1(mdu_src1_0), .mdu_op(mdu_op_0), .mdu_sign(mdu_sign_0),
    .mdu_in_valid(mdu_in_valid_0), .mdu_in_ready(mdu_in_ready), .mdu_out_ready(mdu_out_ready_0),
    .mdu_out_valid(mdu_out_valid), .mdu_res0(u_res0), .mdu_res1(u_res1));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic        m_busy = 1'b0;
  logic [31:0] m_hi = 32'h0, m_lo = 32'h0;
  logic        obs_stall1, obs_stall0, obs_busy;
  logic [31:0] obs_rd1, obs_rd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // {HI, LO} as the unit computes them; divide by zero returns an arbitrary pattern
  function automatic logic [63:0] unit_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint    sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      4'd1:    begin q = sa * sb; return q; end
      4'd2:    return ua * ub;
      4'd3:    begin
                 if (b == 0) return {a, 32'hFFFF_FFFF};
                 q = sa / sb; r = sa % sb;
                 return {r[31:0], q[31:0]};
               end
      default: begin
                 if (b == 0) return {a, 32'hFFFF_FFFF};
                 return {a % b, a / b};
               end
    endcase
  endfunction

  task automatic step(input logic rst, input logic v, input logic k, input logic [3:0] op,
                      input logic [31:0] rs, input logic [31:0] rt, input logic rdy);
    logic arith, mf, mt, real_op, iss, byp, st;
    logic [31:0] rd;
    logic [63:0] res;
    @(negedge clk);
    reset = rst; e_valid = v; e_kill = k; e_md_op = op; e_rs = rs; e_rt = rt; mdu_in_ready = rdy;
    #1;
    arith   = (op >= 1) && (op <= 4);
    mf      = (op == 5) || (op == 6);
    mt      = (op == 7) || (op == 8);
    real_op = (op >= 1) && (op <= 8);
    iss     = !m_busy && v && !k && arith && rdy;
    check("in_valid1", mdu_in_valid_1, iss);
    check("in_valid0", mdu_in_valid_0, iss);
    check("mdu_op", mdu_op_1, iss ? ((op <= 2) ? 2'b01 : 2'b10) : 2'b00);
    check("mdu_sign", mdu_sign_1, iss && (op == 1 || op == 3));
    check("out_ready", mdu_out_ready_0, m_busy);
    check("busy", md_busy_1, m_busy);
    check("src0", mdu_src0_0, rs);
    check("src1", mdu_src1_1, rt);
    for (int b = 0; b < 2; b++) begin
      byp = (b == 1) && m_busy && mdu_out_valid;
      st  = v && real_op && (m_busy ? !(mf && byp) : (arith && !rdy));
      rd  = !mf ? 32'h0 : byp ? ((op == 5) ? u_res1 : u_res0) : ((op == 5) ? m_hi : m_lo);
      if (b == 1) begin check("stall_byp1", md_stall_1, st); check("rdata_byp1", md_rdata_1, rd); end
      else        begin check("stall_byp0", md_stall_0, st); check("rdata_byp0", md_rdata_0, rd); end
    end
    obs_stall1 = md_stall_1; obs_stall0 = md_stall_0;
    obs_rd1 = md_rdata_1; obs_rd0 = md_rdata_0; obs_busy = md_busy_1;
    @(posedge clk);
    #1;
    if (rst) begin
      m_busy = 0; m_hi = 0; m_lo = 0; u_busy = 0; u_cnt = 0;
    end else if (m_busy) begin
      if (mdu_out_valid) begin
        m_hi = u_res1; m_lo = u_res0; m_busy = 0; u_busy = 0;
      end else u_cnt--;
    end else begin
      if (iss) begin
        res = unit_result(op, rs, rt);
        u_res1 = res[63:32]; u_res0 = res[31:0];
        m_busy = 1; u_busy = 1;
        u_cnt = (op <= 2) ? 0 : (force_lat >= 0 ? force_lat : int'($urandom_range(5, 0)));
      end
      if (v && !k && mt) begin
        if (op == 7) m_hi = rs; else m_lo = rs;
      end
    end
  endtask

  // hold one instruction in E until the BYPASS=0 controller stops stalling it
  task automatic run_instr(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                           output logic [31:0] rd1, output logic [31:0] rd0, output int st1, output int st0);
    bit got1, done;
    got1 = 0; done = 0; st1 = 0; st0 = 0; rd1 = 0; rd0 = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step(1'b0, 1'b1, 1'b0, op, rs, rt, 1'b1);
      if (!got1) begin
        if (obs_stall1) st1++; else begin got1 = 1; rd1 = obs_rd1; end
      end
      if (obs_stall0) st0++; else begin rd0 = obs_rd0; done = 1; end
    end
    if (!done) check("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1);
  endtask

  logic [31:0] r1, r0;
  int s1, s0;

  initial begin
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    check("rst_busy", obs_busy, 1'b0);
    run_instr(4'd5, 0, 0, r1, r0, s1, s0);
    check("rst_hi", r0, 32'h0);

    // signed and unsigned multiply, single-cycle issue
    run_instr(4'd1, 32'hFFFF_FFFE, 32'd3, r1, r0, s1, s0);
    check("mult_nostall", s0, 0);
    idle(2);
    run_instr(4'd5, 0, 0, r1, r0, s1, s0); check("mult_hi", r0, 32'hFFFF_FFFF);
    run_instr(4'd6, 0, 0, r1, r0, s1, s0); check("mult_lo", r0, 32'hFFFF_FFFA);
    run_instr(4'd2, 32'hFFFF_FFFE, 32'd3, r1, r0, s1, s0);
    idle(2);
    run_instr(4'd5, 0, 0, r1, r0, s1, s0); check("multu_hi", r0, 32'h0000_0002);
    run_instr(4'd6, 0, 0, r1, r0, s1, s0); check("multu_lo", r0, 32'hFFFF_FFFA);

    // killed multiply leaves HI/LO alone
    step(1'b0, 1'b1, 1'b1, 4'd1, 32'h7, 32'h9, 1'b1);
    check("kill_stall", obs_stall1, 1'b0);
    check("kill_idle", md_busy_1, 1'b0);
    run_instr(4'd5, 0, 0, r1, r0, s1, s0); check("kill_hi", r0, 32'h0000_0002);

    // signed / unsigned divide, MF directly behind it
    force_lat = 4;
    run_instr(4'd3, 32'hFFFF_FFF9, 32'd2, r1, r0, s1, s0);
    run_instr(4'd6, 0, 0, r1, r0, s1, s0);
    check("div_mflo", r0, 32'hFFFF_FFFD);
    check("div_mflo_stalled", s0 > 0, 1'b1);
    run_instr(4'd5, 0, 0, r1, r0, s1, s0); check("div_hi", r0, 32'hFFFF_FFFF);
    run_instr(4'd4, 32'd7, 32'd2, r1, r0, s1, s0);
    run_instr(4'd6, 0, 0, r1, r0, s1, s0); check("divu_lo", r0, 32'd3);
    run_instr(4'd5, 0, 0, r1, r0, s1, s0); check("divu_hi", r0, 32'd1);

    // MTHI behind a divide waits for completion and then overrides HI
    run_instr(4'd3, 32'd100, 32'd7, r1, r0, s1, s0);
    run_instr(4'd7, 32'h1234_5678, 0, r1, r0, s1, s0);
    check("mthi_stalled", s0 > 0, 1'b1);
    run_instr(4'd5, 0, 0, r1, r0, s1, s0); check("mthi_hi", r0, 32'h1234_5678);
    run_instr(4'd6, 0, 0, r1, r0, s1, s0); check("mthi_lo", r0, 32'd14);

    // bypass: MFHI in the out_valid cycle
    run_instr(4'd1, 32'h0001_0000, 32'h0001_0000, r1, r0, s1, s0);
    run_instr(4'd5, 0, 0, r1, r0, s1, s0);
    check("byp1_stalls", s1, 0);
    check("byp0_stalls", s0, 1);
    check("byp1_rdata", r1, 32'h1);
    check("byp0_rdata", r0, 32'h1);

    // reset in the middle of a divide
    run_instr(4'd4, 32'd1000, 32'd3, r1, r0, s1, s0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4'd5, 0, 0, 1'b1);
    check("rst_mid_busy", obs_busy, 1'b0);
    check("rst_mid_stall", obs_stall1, 1'b0);
    check("rst_mid_hi", obs_rd0, 32'h0);
    run_instr(4'd6, 0, 0, r1, r0, s1, s0); check("rst_mid_lo", r0, 32'h0);
    force_lat = -1;
    run_instr(4'd2, 32'd5, 32'd6, r1, r0, s1, s0);
    idle(2);
    run_instr(4'd6, 0, 0, r1, r0, s1, s0); check("multu_30", r0, 32'd30);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = ($urandom_range(3, 0) == 0) ? 32'h0 : (($urandom_range(1, 0) == 1) ? $urandom_range(20, 0) : $urandom());
      step($urandom_range(99, 0) < 2, $urandom_range(9, 0) < 8, $urandom_range(9, 0) == 0,
           4'($urandom_range(15, 0)), a, b, $urandom_range(3, 0) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
